// File: rtl/mem_arb_ctrl_if.sv
// Bus bundle for mem_arb_ctrl: requester channels, RAM port and global enable/flush.
// The slave modport is the arbiter side; the master modport is the requester/RAM side.
interface mem_arb_ctrl_if #(
    parameter int unsigned NCH = 2,
    parameter int unsigned AW  = 32
) ();
    logic                rdy_in;
    logic                flush_in;
    logic [7:0]          mem_din;
    logic [7:0]          mem_dout;
    logic [AW-1:0]       mem_a;
    logic                mem_wr;
    logic [NCH-1:0]      req;
    logic [NCH-1:0]      we;
    logic [NCH-1:0]      sext;
    logic [2*NCH-1:0]    size;
    logic [AW*NCH-1:0]   addr;
    logic [32*NCH-1:0]   wdata;
    logic [NCH-1:0]      done;
    logic [31:0]         rdata;

    modport slave (
        input  rdy_in, flush_in, mem_din, req, we, sext, size, addr, wdata,
        output mem_dout, mem_a, mem_wr, done, rdata
    );

    modport master (
        output rdy_in, flush_in, mem_din, req, we, sext, size, addr, wdata,
        input  mem_dout, mem_a, mem_wr, done, rdata
    );
endinterface

// File: rtl/mem_arb_ctrl.sv
// Round-robin arbiter that serialises per-channel byte/half/word loads and stores
// onto a byte-wide RAM port with one cycle of read latency.
module mem_arb_ctrl #(
    parameter int unsigned NCH = 2,
    parameter int unsigned AW  = 32
) (
    input logic           clk_in,
    input logic           rst_in,
    mem_arb_ctrl_if.slave bus
);
    localparam int unsigned IW = $clog2(NCH);

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  ch_q, ch_d;
    logic [IW-1:0]  last_q, last_d;
    logic           sext_q, sext_d;
    logic [2:0]     nbytes_q, nbytes_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [AW-1:0]  base_q, base_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    rbuf_q, rbuf_d;
    logic [AW-1:0]  mem_a_q, mem_a_d;
    logic           mem_wr_q, mem_wr_d;
    logic [7:0]     mem_dout_q, mem_dout_d;
    logic [NCH-1:0] done_q, done_d;
    logic [31:0]    rdata_q, rdata_d;

    logic           gnt_vld;
    logic [IW-1:0]  gnt_idx;
    int unsigned    cand;
    logic           ext;

    function automatic logic [2:0] nbytes_of(input logic [1:0] sz);
        unique case (sz)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Scan upward from the channel after the last winner, wrapping around.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = last_q;
        cand    = 0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            cand = (32'(last_q) + i) % NCH;
            if (!gnt_vld && bus.req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = IW'(cand);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        last_d     = last_q;
        sext_d     = sext_q;
        nbytes_d   = nbytes_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        mem_a_d    = mem_a_q;
        mem_wr_d   = mem_wr_q;
        mem_dout_d = mem_dout_q;
        done_d     = done_q;
        rdata_d    = rdata_q;
        ext        = 1'b0;

        if (bus.rdy_in) begin
            done_d = '0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_vld) begin
                        ch_d     = gnt_idx;
                        last_d   = gnt_idx;
                        sext_d   = bus.sext[gnt_idx];
                        nbytes_d = nbytes_of(bus.size[2*gnt_idx +: 2]);
                        base_d   = bus.addr[AW*gnt_idx +: AW];
                        wdata_d  = bus.wdata[32*gnt_idx +: 32];
                        cnt_d    = 3'd1;
                        mem_a_d  = bus.addr[AW*gnt_idx +: AW];
                        if (bus.we[gnt_idx]) begin
                            state_d    = StWrite;
                            mem_wr_d   = 1'b1;
                            mem_dout_d = bus.wdata[32*gnt_idx +: 8];
                        end else begin
                            state_d  = StRead;
                            mem_wr_d = 1'b0;
                        end
                    end
                end
                StWrite: begin
                    if (cnt_q == nbytes_q) begin
                        state_d      = StIdle;
                        mem_wr_d     = 1'b0;
                        mem_a_d      = '0;
                        done_d[ch_q] = 1'b1;
                    end else begin
                        mem_a_d    = base_q + AW'(cnt_q);
                        mem_dout_d = wdata_q[8*cnt_q +: 8];
                        cnt_d      = cnt_q + 3'd1;
                    end
                end
                StRead: begin
                    if (bus.flush_in) begin
                        state_d = StIdle;
                        mem_a_d = '0;
                    end else if (cnt_q == nbytes_q + 3'd1) begin
                        // Final byte comes straight from the RAM, not the buffer.
                        ext = sext_q & bus.mem_din[7];
                        unique case (nbytes_q)
                            3'd1:    rdata_d = {{24{ext}}, bus.mem_din};
                            3'd2:    rdata_d = {{16{ext}}, bus.mem_din, rbuf_q[7:0]};
                            default: rdata_d = {bus.mem_din, rbuf_q[23:0]};
                        endcase
                        state_d      = StIdle;
                        mem_a_d      = '0;
                        done_d[ch_q] = 1'b1;
                    end else begin
                        if (cnt_q < nbytes_q) begin
                            mem_a_d = base_q + AW'(cnt_q);
                        end
                        // Data for the address issued two edges ago is on mem_din now.
                        if (cnt_q >= 3'd2) begin
                            rbuf_d[8*(cnt_q-3'd2) +: 8] = bus.mem_din;
                        end
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            ch_q       <= '0;
            last_q     <= IW'(NCH - 1);
            sext_q     <= 1'b0;
            nbytes_q   <= 3'd1;
            cnt_q      <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            mem_a_q    <= '0;
            mem_wr_q   <= 1'b0;
            mem_dout_q <= '0;
            done_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            last_q     <= last_d;
            sext_q     <= sext_d;
            nbytes_q   <= nbytes_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            mem_a_q    <= mem_a_d;
            mem_wr_q   <= mem_wr_d;
            mem_dout_q <= mem_dout_d;
            done_q     <= done_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.mem_a    = mem_a_q;
    assign bus.mem_wr   = mem_wr_q;
    assign bus.mem_dout = mem_dout_q;
    assign bus.done     = done_q;
    assign bus.rdata    = rdata_q;
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Directed bench for mem_arb_ctrl with three channels and a 16-bit address space,
// backed by a byte RAM model with one cycle of read latency.
module tb_mem_arb_ctrl;
    localparam int unsigned NCH = 3;
    localparam int unsigned AW  = 16;

    logic clk;
    logic rst;

    mem_arb_ctrl_if #(.NCH(NCH), .AW(AW)) bus ();

    mem_arb_ctrl #(.NCH(NCH), .AW(AW)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM stalls together with the arbiter so a paused read resumes on the same data.
    logic [7:0] ram [0:65535];
    always @(posedge clk) begin
        if (bus.rdy_in) begin
            if (bus.mem_wr) ram[bus.mem_a] <= bus.mem_dout;
            bus.mem_din <= ram[bus.mem_a];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic w, input logic s, input logic [1:0] sz,
                          input logic [15:0] a, input logic [31:0] d);
        bus.we[c]               = w;
        bus.sext[c]             = s;
        bus.size[2*c +: 2]      = sz;
        bus.addr[AW*c +: AW]    = a;
        bus.wdata[32*c +: 32]   = d;
    endtask

    task automatic expect_wr(input string tag, input logic [15:0] a, input logic [7:0] d);
        check({tag, "_wr"}, 32'(bus.mem_wr), 32'd1);
        check({tag, "_a"}, 32'(bus.mem_a), 32'(a));
        check({tag, "_dout"}, 32'(bus.mem_dout), 32'(d));
    endtask

    function automatic int ch_of(input logic [2:0] d);
        case (d)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 7;
        endcase
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] wd;
        logic [7:0]  rr_byte [3];
        int got;
        int last_t;
        int ch;

        rst          = 1'b1;
        bus.rdy_in   = 1'b1;
        bus.flush_in = 1'b0;
        bus.req      = '0;
        bus.we       = '0;
        bus.sext     = '0;
        bus.size     = '0;
        bus.addr     = '0;
        bus.wdata    = '0;
        tick();
        tick();
        check("rst_mem_a", 32'(bus.mem_a), 32'd0);
        check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("rst_mem_dout", 32'(bus.mem_dout), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        rst = 1'b0;

        // Word store on ch0; req dropped right after grant must not abort it.
        wd = 32'hAABBCCDD;
        set_ch(0, 1'b1, 1'b0, 2'd2, 16'h0100, wd);
        bus.req = 3'b001;
        tick();
        bus.req = 3'b000;
        expect_wr("wst0", 16'h0100, 8'hDD);
        for (int k = 1; k < 4; k++) begin
            tick();
            expect_wr("wst", 16'(16'h0100 + k), wd[8*k +: 8]);
            check("wst_nodone", 32'(bus.done), 32'd0);
        end
        tick();
        check("wst_done", 32'(bus.done), 32'b001);
        check("wst_end_wr", 32'(bus.mem_wr), 32'd0);
        check("wst_end_a", 32'(bus.mem_a), 32'd0);
        tick();
        check("wst_done_pulse", 32'(bus.done), 32'd0);

        // Half store preloads 0x34/0xF2 at 0x200; rdata must not move on a write.
        set_ch(0, 1'b1, 1'b0, 2'd1, 16'h0200, 32'h0000F234);
        bus.req = 3'b001;
        tick();
        bus.req = 3'b000;
        expect_wr("hst0", 16'h0200, 8'h34);
        tick();
        expect_wr("hst1", 16'h0201, 8'hF2);
        tick();
        check("hst_done", 32'(bus.done), 32'b001);
        check("hst_rdata", bus.rdata, 32'd0);
        tick();

        // Signed half load on ch1; a short ch2 req pulse during it must be ignored.
        set_ch(1, 1'b0, 1'b1, 2'd1, 16'h0200, 32'd0);
        set_ch(2, 1'b0, 1'b0, 2'd0, 16'h0100, 32'd0);
        bus.req = 3'b010;
        tick();
        check("hld_g_wr", 32'(bus.mem_wr), 32'd0);
        check("hld_g_a", 32'(bus.mem_a), 32'h0200);
        bus.req = 3'b000;
        tick();
        check("hld_g1_a", 32'(bus.mem_a), 32'h0201);
        bus.req = 3'b100;
        tick();
        check("hld_g2_nodone", 32'(bus.done), 32'd0);
        bus.req = 3'b000;
        tick();
        check("hld_done", 32'(bus.done), 32'b010);
        check("hld_rdata_s", bus.rdata, 32'hFFFFF234);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("stale_req_unserved", 32'(bus.done), 32'd0);
        end

        set_ch(1, 1'b0, 1'b0, 2'd1, 16'h0200, 32'd0);
        bus.req = 3'b010;
        tick();
        bus.req = 3'b000;
        tick();
        tick();
        tick();
        check("hld_u_done", 32'(bus.done), 32'b010);
        check("hld_rdata_u", bus.rdata, 32'h0000F234);
        tick();

        // Signed byte load of 0xAA.
        set_ch(0, 1'b0, 1'b1, 2'd0, 16'h0103, 32'd0);
        bus.req = 3'b001;
        tick();
        bus.req = 3'b000;
        tick();
        check("bld_nodone", 32'(bus.done), 32'd0);
        tick();
        check("bld_done", 32'(bus.done), 32'b001);
        check("bld_rdata", bus.rdata, 32'hFFFFFFAA);
        tick();

        // size=3 behaves as a word.
        set_ch(2, 1'b0, 1'b1, 2'd3, 16'h0100, 32'd0);
        bus.req = 3'b100;
        tick();
        bus.req = 3'b000;
        check("s3_g_a", 32'(bus.mem_a), 32'h0100);
        tick();
        tick();
        tick();
        tick();
        check("s3_nodone", 32'(bus.done), 32'd0);
        tick();
        check("s3_done", 32'(bus.done), 32'b100);
        check("s3_rdata", bus.rdata, 32'hAABBCCDD);
        tick();

        // Word load paused for three cycles after G+1.
        set_ch(0, 1'b0, 1'b0, 2'd2, 16'h0100, 32'd0);
        bus.req = 3'b001;
        tick();
        bus.req = 3'b000;
        tick();
        check("pz_g1_a", 32'(bus.mem_a), 32'h0101);
        bus.rdy_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("pz_hold_a", 32'(bus.mem_a), 32'h0101);
            check("pz_hold_done", 32'(bus.done), 32'd0);
        end
        bus.rdy_in = 1'b1;
        tick();
        check("pz_a2", 32'(bus.mem_a), 32'h0102);
        tick();
        check("pz_a3", 32'(bus.mem_a), 32'h0103);
        tick();
        check("pz_nodone", 32'(bus.done), 32'd0);
        tick();
        check("pz_done", 32'(bus.done), 32'b001);
        check("pz_rdata", bus.rdata, 32'hAABBCCDD);
        tick();

        // Word store wrapping past 0xFFFF with flush held high (no effect on writes).
        wd = 32'h11223344;
        set_ch(1, 1'b1, 1'b0, 2'd2, 16'hFFFE, wd);
        bus.req      = 3'b010;
        bus.flush_in = 1'b1;
        tick();
        bus.req = 3'b000;
        expect_wr("wrap0", 16'hFFFE, 8'h44);
        tick();
        expect_wr("wrap1", 16'hFFFF, 8'h33);
        tick();
        expect_wr("wrap2", 16'h0000, 8'h22);
        tick();
        expect_wr("wrap3", 16'h0001, 8'h11);
        tick();
        bus.flush_in = 1'b0;
        check("wrap_done", 32'(bus.done), 32'b010);
        check("wrap_rdata_kept", bus.rdata, 32'hAABBCCDD);
        tick();

        // Round robin with all three channels requesting continuously from reset.
        rst = 1'b1;
        tick();
        check("rst2_rdata", bus.rdata, 32'd0);
        rst = 1'b0;
        set_ch(0, 1'b0, 1'b0, 2'd0, 16'h0100, 32'd0);
        set_ch(1, 1'b0, 1'b0, 2'd0, 16'h0101, 32'd0);
        set_ch(2, 1'b0, 1'b0, 2'd0, 16'h0102, 32'd0);
        rr_byte[0] = 8'hDD;
        rr_byte[1] = 8'hCC;
        rr_byte[2] = 8'hBB;
        bus.req = 3'b111;
        got    = 0;
        last_t = 0;
        for (int t = 0; t < 40 && got < 6; t++) begin
            tick();
            if (bus.done != 3'b000) begin
                ch = ch_of(bus.done);
                check("rr_order", 32'(ch), 32'(got % 3));
                if (ch < 3) check("rr_rdata", bus.rdata, {24'd0, rr_byte[ch]});
                if (got > 0) check("rr_gap", 32'(t - last_t), 32'd3);
                last_t = t;
                got++;
            end
        end
        bus.req = 3'b000;
        check("rr_count", 32'(got), 32'd6);

        // Flush a ch0 word load at G+2; pending ch1 is granted at the next edge.
        set_ch(0, 1'b0, 1'b0, 2'd2, 16'h0100, 32'd0);
        set_ch(1, 1'b0, 1'b1, 2'd0, 16'h0101, 32'd0);
        bus.req = 3'b011;
        tick();
        check("fl_g_a", 32'(bus.mem_a), 32'h0100);
        bus.req = 3'b010;
        tick();
        check("fl_g1_a", 32'(bus.mem_a), 32'h0101);
        bus.flush_in = 1'b1;
        tick();
        bus.flush_in = 1'b0;
        check("fl_a0", 32'(bus.mem_a), 32'd0);
        check("fl_nodone", 32'(bus.done), 32'd0);
        check("fl_rdata_kept", bus.rdata, 32'h000000BB);
        tick();
        check("fl_next_a", 32'(bus.mem_a), 32'h0101);
        check("fl_next_wr", 32'(bus.mem_wr), 32'd0);
        bus.req = 3'b000;
        tick();
        check("fl_next_nodone", 32'(bus.done), 32'd0);
        tick();
        check("fl_next_done", 32'(bus.done), 32'b010);
        check("fl_next_rdata", bus.rdata, 32'hFFFFFFCC);
        tick();

        // Reset at G+1 of a store, with rdy low to show reset wins.
        set_ch(2, 1'b1, 1'b0, 2'd2, 16'h0300, 32'h55667788);
        bus.req = 3'b100;
        tick();
        expect_wr("rs_g", 16'h0300, 8'h88);
        rst        = 1'b1;
        bus.rdy_in = 1'b0;
        bus.req    = 3'b000;
        tick();
        check("rs_wr", 32'(bus.mem_wr), 32'd0);
        check("rs_a", 32'(bus.mem_a), 32'd0);
        check("rs_done", 32'(bus.done), 32'd0);
        rst        = 1'b0;
        bus.rdy_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rs_after_done", 32'(bus.done), 32'd0);
            check("rs_after_wr", 32'(bus.mem_wr), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_arb_ctrl.md
MEM_ARB_CTRL -- requirements
Module: mem_arb_ctrl

Interface
REQ-001 Parameter NCH, default 2: number of request channels; range 2..8.
REQ-002 Parameter AW, default 32: address width.
REQ-003 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_in  input  1  synchronous, active-high reset.
REQ-005 rdy_in  input  1  global enable; low freezes all state and outputs.
REQ-006 flush_in  input  1  abort in-flight read; pending writes unaffected.
REQ-007 mem_din  input  8  RAM read byte.
REQ-008 mem_dout  output  8  RAM write byte, registered.
REQ-009 mem_a  output  AW  RAM byte address, registered.
REQ-010 mem_wr  output  1  1 = write, 0 = read, registered.
REQ-011 req  input  NCH  per-channel request level.
REQ-012 we  input  NCH  per-channel write flag.
REQ-013 sext  input  NCH  per-channel sign-extend-load flag.
REQ-014 size  input  2*NCH  per-channel size: 0 = byte, 1 = half, 2 or 3 = word.
REQ-015 addr  input  AW*NCH  per-channel start address, channel c in bits [c*AW +: AW].
REQ-016 wdata  input  32*NCH  per-channel store data, little-endian.
REQ-017 done  output  NCH  one-cycle completion pulse per channel.
REQ-018 rdata  output  32  load result shared by all channels, valid while done is high.

Function
REQ-019 States:
- IDLE: no transaction.
- WRITE: emitting store bytes.
- READ: issuing addresses and capturing bytes.

REQ-020 Grant:
- Occurs only in IDLE with rdy_in=1 and at least one req bit set.
- Winner is the first set req bit, scanning upward (with wrap-around) from last_grant+1.

REQ-021 At the grant edge G the block SHALL:
- latch the channel index, we, sext, size, addr and wdata;
- set last_grant to the winner;
- drive mem_a to the start address A.

REQ-022 Byte count n is 1, 2 or 4 according to size; a size of 3 SHALL be treated as 4.

REQ-023 Write transfer:
- At edges G..G+n-1: mem_wr=1, mem_a=A+k, mem_dout=wdata byte k.
- At edge G+n: mem_wr=0, mem_a=0, done[c]=1, state returns to IDLE.

REQ-024 Read transfer:
- At edges G..G+n-1: mem_wr=0, mem_a=A+k.
- Byte k is sampled from mem_din at edge G+k+2, since the RAM has 1-cycle latency.

REQ-025 Read completion at edge G+n+1:
- rdata and done[c] are registered together.
- The last byte is taken directly from mem_din.
- State returns to IDLE.

REQ-026 Read result formatting:
- Bytes are assembled little-endian into rdata.
- Upper bits are zero-filled, or filled with the top bit of the top loaded byte when sext=1.

REQ-027 Address increment SHALL wrap modulo 2^AW.

REQ-028 done SHALL be one-hot or zero, and high for exactly one cycle per completed transaction.

REQ-029 rdata SHALL hold its value until the next read completion; a write completion SHALL NOT change rdata.

REQ-030 Minimum spacing: after any completion the block spends at least one cycle in IDLE; the earliest next grant is edge completion+1.

REQ-031 A req bit deasserted before its grant SHALL NOT be served.
REQ-032 Deasserting req after the grant SHALL NOT abort the transaction.

REQ-033 Requesters hold req high until they see their done pulse, then drop req on the following edge; otherwise they are re-granted.

REQ-034 flush_in=1 in READ:
- At that edge, return to IDLE with no done pulse and set mem_a=0.
- last_grant remains updated.

REQ-035 flush_in=1 in WRITE or IDLE SHALL have no effect.

REQ-036 rdy_in=0 SHALL hold state, counters, mem_a, mem_wr, mem_dout, done and rdata unchanged, with no byte sampled.
REQ-037 When rdy_in returns high, the transfer SHALL resume cycle-for-cycle.

REQ-038 Simultaneous requests: all losers wait; the round-robin rule SHALL guarantee each requester a grant within NCH transactions.

Reset
REQ-039 The rst_in reset values SHALL be:
- state=IDLE;
- mem_a=0, mem_wr=0, mem_dout=0;
- done=0, rdata=0;
- last_grant=NCH-1, so channel 0 has first priority.

REQ-040 rst_in mid-transaction SHALL abort it at that edge with no done pulse and no further RAM write.

REQ-041 rst_in SHALL take precedence over rdy_in and flush_in.

Verification
REQ-042 Word store:
- Stimulus: ch0 we=1 size=2 addr=0x100 wdata=0xAABBCCDD.
- Response: mem_wr=1 with (a,dout) = (0x100,DD), (0x101,CC), (0x102,BB), (0x103,AA); done[0] at G+4.

REQ-043 Signed half load:
- Stimulus: ch1 size=1 sext=1 addr=0x200, RAM holds 0x34 at 0x200 and 0xF2 at 0x201.
- Response: done[1] at G+3 with rdata=0xFFFFF234; with sext=0, rdata=0x0000F234.

REQ-044 Round-robin fairness:
- Stimulus: NCH=3, all req held high continuously from reset.
- Response: grant order 0,1,2,0,1,2; each done is separated by at least one IDLE cycle.

REQ-045 Read flush:
- Stimulus: ch0 word load, flush_in pulsed at G+2.
- Response: no done pulse, mem_a=0 next cycle, rdata keeps its previous value; a pending ch1 request is granted at the following edge.

REQ-046 Pause and reset:
- Stimulus: rdy_in=0 for 3 cycles mid word-load.
- Response: outputs frozen and done arrives 3 cycles late with correct data.
- Stimulus: rst_in at G+1 of a store.
- Response: mem_wr=0 next cycle, done never pulses.
